cla_multiword_add_seq: RTL and testbench
========================================

Name: cla_multiword_add_seq

Overview:
Multi-cycle sequencer that computes wide add/subtract (default 64-bit) by reusing one SLICE_W-bit carry-lookahead adder slice, least-significant slice first. Slice carry-out is registered and fed to the next slice's carry-in on the following cycle. Sits between the accumulator/requantisation logic and the shared CLA slice in the inference datapath. Uses a valid/ready handshake on both input and output.

Parameters:
SLICE_W, 16, width of the shared CLA slice in bits.
NUM_SLICES, 4, slices per operand; total width W = SLICE_W*NUM_SLICES. Must be at least 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept an operation.
op_a  input  W  operand A.
op_b  input  W  operand B.
sub  input  1  1 computes A-B, 0 computes A+B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  W  result.
carry_out  output  1  raw carry out of MSB. For subtract, 1 means no borrow.
overflow  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-low on `rst_n`, sampled on the rising edge of `clk`.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, slice index=0, carry register=0.
- Reset mid-operation (RUN or DONE): the in-flight operation is discarded with no partial output. The next cycle shows IDLE reset values.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid&in_ready (the accept edge E0). On this edge:
  - latch A;
  - latch B_eff = sub ? ~op_b : op_b;
  - carry register = sub;
  - slice index = 0.
- RUN, each cycle, for slice k = index:
  - slice inputs: A[k], B_eff[k], carry register;
  - write slice sum into sum[k*SLICE_W +: SLICE_W];
  - carry register = slice carry-out;
  - index = index+1.
- At the final slice (k = NUM_SLICES-1):
  - carry_out = slice carry-out;
  - overflow = carry into bit W-1 XOR carry out of bit W-1;
  - state -> DONE.
  - The slice must expose carry into its MSB, or the block computes it from the slice MSB inputs and output.
- Latency: out_valid rises NUM_SLICES cycles after the accept edge (4 at defaults).
- DONE: sum, carry_out and overflow are held stable while out_valid=1. On out_valid&out_ready -> IDLE; out_valid=0 next cycle.
- Throughput: at most one operation per NUM_SLICES+1 cycles. No accept is allowed in DONE, even if out_ready is high in the same cycle.
- in_valid while in_ready=0 is ignored; operands are not sampled.
- Operands are sampled only at the accept edge. Changes on op_a/op_b/sub afterwards have no effect.
- Sum bits not yet written during RUN hold stale values. They are only defined while out_valid=1.
- Width rule: all arithmetic is modulo 2^W. No saturation.

Optional Feature:
Macro CLA_SEQ_EARLY_EXIT_EN.
- Defined, after slice k < NUM_SLICES-1 completes, exit early when both hold:
  - the slice carry-out is 0;
  - A and B_eff bits above slice k are all zero.
- On early exit:
  - the remaining sum slices are written 0 on that same edge;
  - carry_out=0, overflow=0;
  - state -> DONE.
  - Latency becomes k+1 cycles.
- Not defined: always NUM_SLICES RUN cycles. No early-exit comparator logic is present.
- Results must be bit-identical with and without the macro.

Test Plan:
1. a=0x0000_0000_0000_FFFF, b=0x1, sub=0 -> sum=0x0000_0000_0001_0000, carry_out=0, overflow=0; out_valid 4 cycles after accept (2 cycles with CLA_SEQ_EARLY_EXIT_EN).
2. a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0x0, carry_out=1, overflow=0 (carry ripples through all 4 slices).
3. a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0x8000_0000_0000_0000, carry_out=0, overflow=1.
4. a=0x5, b=0x7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0. Then a=0x8000_0000_0000_0000, b=0x1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, carry_out=1, overflow=1.
5. Backpressure: complete test 1 with out_ready=0 for 10 cycles and in_valid=1 carrying different operands -> sum/flags stable, in_ready=0, second request not taken. out_ready=1 -> IDLE next cycle, then second request accepted.
6. Reset mid-op: drop rst_n for one cycle 2 cycles after accept -> next cycle out_valid=0, in_ready=1, sum=0. The following op a=1, b=2 -> sum=0x3.

Source files
------------

// File: rtl/cla_multiword_add_seq.sv
// cla_multiword_add_seq: wide add/subtract built by reusing a single SLICE_W-bit
// carry-lookahead slice, least-significant slice first, one slice per cycle.
// The slice carry-out is registered and becomes the next slice's carry-in.
// Valid/ready handshake on both the operand side and the result side.
// Optional feature macro: CLA_SEQ_EARLY_EXIT_EN -- finish early once the
// remaining upper operand bits are zero and no carry is pending.
module cla_multiword_add_seq #(
  parameter int SLICE_W    = 16,
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] op_a,
  input  logic [SLICE_W*NUM_SLICES-1:0] op_b,
  input  logic                          sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] sum,
  output logic                          carry_out,
  output logic                          overflow
);

  localparam int W  = SLICE_W * NUM_SLICES;
  localparam int IW = $clog2(NUM_SLICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  int              w_base;
  logic [SLICE_W-1:0] w_sliceA;
  logic [SLICE_W-1:0] w_sliceB;
  logic [SLICE_W:0]   w_sliceRes;
  logic [SLICE_W-1:0] w_sliceSum;
  logic            w_sliceCout;
  logic            w_msbCin;
  logic            w_lastSlice;
  logic [W-1:0]    w_sumNext;
  logic [W-1:0]    w_sumWrite;
  logic            w_earlyExit;

  // Shared slice: selects the active operand slice and adds it with the pending carry
  always_comb begin
    w_base      = int'(r_idx) * SLICE_W;
    w_sliceA    = r_a[w_base +: SLICE_W];
    w_sliceB    = r_b[w_base +: SLICE_W];
    w_sliceRes  = {1'b0, w_sliceA} + {1'b0, w_sliceB} + {{SLICE_W{1'b0}}, r_carry};
    w_sliceSum  = w_sliceRes[SLICE_W-1:0];
    w_sliceCout = w_sliceRes[SLICE_W];
    w_msbCin    = w_sliceA[SLICE_W-1] ^ w_sliceB[SLICE_W-1] ^ w_sliceSum[SLICE_W-1];
    w_lastSlice = (r_idx == LAST_IDX);
    w_sumNext   = r_sum;
    w_sumNext[w_base +: SLICE_W] = w_sliceSum;
  end

`ifdef CLA_SEQ_EARLY_EXIT_EN
  logic [W-1:0] w_keepMask;
  logic         w_upperZero;

  // Early exit: nothing left above this slice and no carry pending, so upper slices are zero
  always_comb begin
    w_upperZero = (((r_a | r_b) >> (w_base + SLICE_W)) == '0);
    w_keepMask  = {W{1'b1}} >> (W - w_base - SLICE_W);
    w_earlyExit = !w_lastSlice && !w_sliceCout && w_upperZero;
    w_sumWrite  = w_earlyExit ? (w_sumNext & w_keepMask) : w_sumNext;
  end
`else
  // Without early exit every operation runs all slices
  always_comb begin
    w_earlyExit = 1'b0;
    w_sumWrite  = w_sumNext;
  end
`endif

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = RUN;
      end
      RUN: begin
        if (w_lastSlice || w_earlyExit) w_stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then write one result slice per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sumWrite;
          r_carry <= w_sliceCout;
          r_idx   <= r_idx + 1'b1;
          if (w_lastSlice) begin
            r_cout <= w_sliceCout;
            r_ovf  <= w_msbCin ^ w_sliceCout;
          end else if (w_earlyExit) begin
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Testbench for cla_multiword_add_seq: directed corner cases, backpressure,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_cla_multiword_add_seq;

  localparam int SW = 16;
  localparam int NS = 4;
  localparam int W  = SW * NS;
`ifdef CLA_SEQ_EARLY_EXIT_EN
  localparam int LAT_T1   = 2;
  localparam int LAT_RAND = 0;
`else
  localparam int LAT_T1   = NS;
  localparam int LAT_RAND = NS;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  cla_multiword_add_seq #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain wide arithmetic and sign rules
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] wide;
    if (s) begin
      r = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      r = wide[W-1:0];
      c = wide[W];
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
  endtask

  // Present an operation and hold in_valid across exactly one accept edge
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) checkOutput("accept_timeout", 0, 1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    sub  = 1'($urandom);
  endtask

  // Count cycles after the accept edge until out_valid, bounded
  task automatic waitDone(output int lat);
    bit done;
    done = 0;
    lat  = 0;
    while (!done && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) done = 1;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] r;
    logic c, v;
    refModel(a, b, s, r, c, v);
    checkOutput({tag, "_sum"}, sum, r);
    checkOutput({tag, "_cout"}, W'(carry_out), W'(c));
    checkOutput({tag, "_ovf"}, W'(overflow), W'(v));
    checkOutput({tag, "_inrdy"}, W'(in_ready), 0);
  endtask

  // Full transaction; expLat of 0 only bounds the latency
  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int expLat);
    int lat;
    applyStimulus(a, b, s);
    waitDone(lat);
    if (expLat > 0) checkOutput({tag, "_lat"}, W'(lat), W'(expLat));
    else            checkOutput({tag, "_latmax"}, W'(lat <= NS), 1);
    checkResult(tag, a, b, s);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] expSum, a, b;
    logic expC, expV;
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_inrdy", W'(in_ready), 1);
    checkOutput("rst_outvld", W'(out_valid), 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", W'(carry_out), 0);
    checkOutput("rst_ovf", W'(overflow), 0);
    rst_n = 1'b1;

    runOp("t1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, LAT_T1);
    runOp("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, NS);
    runOp("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, NS);
    runOp("t4a", 64'h5, 64'h7, 1'b1, NS);
    runOp("t4b", 64'h8000_0000_0000_0000, 64'h1, 1'b1, NS);

    // Backpressure: result held, second request ignored until release
    applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    waitDone(lat);
    refModel(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, expSum, expC, expV);
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321; sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_sum", sum, expSum);
      checkOutput("bp_cout", W'(carry_out), W'(expC));
      checkOutput("bp_outvld", W'(out_valid), 1);
      checkOutput("bp_inrdy", W'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_rel_outvld", W'(out_valid), 0);
    checkOutput("bp_rel_inrdy", W'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDone(lat);
    checkResult("bp_second", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset two cycles into an operation discards it
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_outvld", W'(out_valid), 0);
    checkOutput("mid_rst_inrdy", W'(in_ready), 1);
    checkOutput("mid_rst_sum", sum, 0);
    rst_n = 1'b1;
    runOp("post_rst", 64'h1, 64'h2, 1'b0, NS);

    // Randomized operations, mixing full-width and small operands
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 3 == 1) begin
        a = a >> $urandom_range(33, 63);
        b = b >> $urandom_range(33, 63);
      end
      runOp("rand", a, b, 1'($urandom), LAT_RAND);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
